sysid_verifier: RTL and testbench

- Avalon-MM read master placed directly downstream of the system-ID slave.
- After reset or on request, it reads the ID word (address 0) and the timestamp word (address 1) and compares each against its expected value.
- Results are exported as status flags for the boot/health logic and an LED/debug port.
- It can optionally re-check periodically and count mismatches.

---
 rtl/sysid_verifier.sv | 150 +++++++++++++++
 tb/tb_sysid_verifier.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_verifier.sv
// rtl/sysid_verifier.sv - Avalon-MM read master that checks the system-ID and timestamp words
module sysid_verifier #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1435806319,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          RECHECK_CYCLES     = 0,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [7:0]  mismatch_count
);

    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ICW = (RECHECK_CYCLES > 1) ? $clog2(RECHECK_CYCLES) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]     LAT_LAST  = 2'(READ_LATENCY - 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(RECHECK_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, DONE} state_t;

    state_t         state, state_n;
    logic           auto_pending;
    logic [WCW-1:0] wait_cnt;
    logic [1:0]     lat_cnt;
    logic [ICW-1:0] idle_cnt;
    logic           abort_r;
    logic           cap_id, cap_ts, abort_now;
    logic           wait_last, lat_last, idle_last;
    logic           id_match, ts_match;

    assign wait_last = (wait_cnt == WAIT_LAST);
    assign lat_last  = (lat_cnt == LAT_LAST);
    assign idle_last = (RECHECK_CYCLES > 0) && (idle_cnt == IDLE_LAST);
    assign busy      = (state != IDLE) && (state != DONE);
    assign id_match  = !abort_r && (id_value == EXPECTED_ID);
    assign ts_match  = !abort_r && (ts_value == EXPECTED_TIMESTAMP);

    always_comb begin
        state_n     = state;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        cap_id      = 1'b0;
        cap_ts      = 1'b0;
        abort_now   = 1'b0;
        case (state)
            IDLE: if (start || auto_pending) state_n = RD_ID;
            RD_ID: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        cap_id  = 1'b1;
                        state_n = RD_TS;
                    end else begin
                        state_n = LAT_ID;
                    end
                end else if (wait_last) begin
                    abort_now = 1'b1;
                    state_n   = CHECK;
                end
            end
            LAT_ID: if (lat_last) begin
                cap_id  = 1'b1;
                state_n = RD_TS;
            end
            RD_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        cap_ts  = 1'b1;
                        state_n = CHECK;
                    end else begin
                        state_n = LAT_TS;
                    end
                end else if (wait_last) begin
                    abort_now = 1'b1;
                    state_n   = CHECK;
                end
            end
            LAT_TS: if (lat_last) begin
                cap_ts  = 1'b1;
                state_n = CHECK;
            end
            CHECK: state_n = DONE;
            DONE: if (start || idle_last) state_n = RD_ID;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            auto_pending   <= AUTO_START;
            wait_cnt       <= '0;
            lat_cnt        <= '0;
            idle_cnt       <= '0;
            abort_r        <= 1'b0;
            id_value       <= '0;
            ts_value       <= '0;
            id_ok          <= 1'b0;
            ts_ok          <= 1'b0;
            timeout        <= 1'b0;
            done           <= 1'b0;
            mismatch_count <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) auto_pending <= 1'b0;

            if (avm_read && avm_waitrequest) wait_cnt <= wait_cnt + WCW'(1);
            else                             wait_cnt <= '0;

            if (state == LAT_ID || state == LAT_TS) lat_cnt <= lat_cnt + 2'd1;
            else                                    lat_cnt <= '0;

            // Idle counter only runs while sitting in DONE; any exit or restart clears it.
            if (state == DONE && state_n == DONE) idle_cnt <= idle_cnt + ICW'(1);
            else                                  idle_cnt <= '0;

            if (cap_id) id_value <= avm_readdata;
            if (cap_ts) ts_value <= avm_readdata;

            if (abort_now)           abort_r <= 1'b1;
            else if (state == CHECK) abort_r <= 1'b0;

            if (state == CHECK) begin
                id_ok   <= id_match;
                ts_ok   <= ts_match;
                timeout <= abort_r;
                done    <= 1'b1;
                if (!(id_match && ts_match) && mismatch_count != 8'hFF)
                    mismatch_count <= mismatch_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sysid_verifier.sv
// tb/tb_sysid_verifier.sv - scoreboard bench for sysid_verifier with a behavioural Avalon slave
module tb_sysid_verifier;

    localparam logic [31:0] GOOD_TS = 32'd1435806319;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address, avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'h0;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;
    logic [7:0]  mismatch_count;

    sysid_verifier #(
        .EXPECTED_ID(32'd0), .EXPECTED_TIMESTAMP(GOOD_TS), .READ_LATENCY(2),
        .TIMEOUT_CYCLES(8), .RECHECK_CYCLES(10), .AUTO_START(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
        .id_value(id_value), .ts_value(ts_value), .mismatch_count(mismatch_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        to;
        logic [7:0]  mm;
        int          blen;
        logic [31:0] idv;
        logic [31:0] tsv;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pushed = 0;
    int   n_done  = 0;
    logic [7:0] exp_mm = 8'd0;

    // slave configuration, changed by stimulus only while the DUT sits in DONE
    logic [31:0] id_word = 32'd0;
    logic [31:0] ts_word = GOOD_TS;
    int          stall_n = 0;
    logic        stuck   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic push_exp(input logic iok, input logic tok, input logic to, input int blen,
                            input logic [31:0] idv, input logic [31:0] tsv);
        exp_t e;
        if ((!(iok && tok) || to) && exp_mm != 8'hFF) exp_mm = exp_mm + 8'd1;
        e.id_ok = iok; e.ts_ok = tok; e.to = to; e.mm = exp_mm;
        e.blen = blen; e.idv = idv; e.tsv = tsv;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic wait_all();
        int budget;
        budget = 40 * (n_pushed - n_done) + 100;
        while (n_done < n_pushed && budget > 0) begin
            tick();
            budget--;
        end
        if (n_done < n_pushed) chk("wait_checks_timeout", 64'(n_done), 64'(n_pushed));
    endtask

    task automatic measure_gap(output int n);
        n = 0;
        while (!busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Slave model and monitor share one process so the slave's waitrequest for
    // the current cycle is already settled when the monitor samples it.
    logic [31:0] q0 = 32'hDEADBEEF, q1 = 32'hDEADBEEF;
    int          st_cnt = 0;
    logic        accept;
    logic        busy_prev = 1'b0, prev_rd_wait = 1'b0, prev_addr = 1'b0;
    int          blen = 0;
    exp_t        e_m;

    initial begin
        forever begin
            @(negedge clock);
            accept = 1'b0;
            if (!avm_read) begin
                st_cnt = 0;
                avm_waitrequest = 1'b0;
            end else if (stuck || st_cnt < stall_n) begin
                avm_waitrequest = 1'b1;
                st_cnt++;
            end else begin
                avm_waitrequest = 1'b0;
                accept = 1'b1;
                st_cnt = 0;
            end
            avm_readdata = q1;
            q1 = q0;
            q0 = accept ? (avm_address ? ts_word : id_word) : 32'hDEADBEEF;

            if (reset) begin
                busy_prev = 1'b0;
                prev_rd_wait = 1'b0;
                blen = 0;
            end else begin
                if (busy) blen++;
                if (busy_prev && !busy) begin
                    n_done++;
                    if (sb.size() == 0) begin
                        chk("unexpected_check", 64'(n_done), 64'(n_pushed));
                    end else begin
                        e_m = sb.pop_front();
                        chk("id_ok", 64'(id_ok), 64'(e_m.id_ok));
                        chk("ts_ok", 64'(ts_ok), 64'(e_m.ts_ok));
                        chk("timeout", 64'(timeout), 64'(e_m.to));
                        chk("mismatch_count", 64'(mismatch_count), 64'(e_m.mm));
                        chk("id_value", 64'(id_value), 64'(e_m.idv));
                        chk("ts_value", 64'(ts_value), 64'(e_m.tsv));
                        chk("busy_cycles", 64'(blen), 64'(e_m.blen));
                        chk("done_flag", 64'(done), 64'd1);
                    end
                    blen = 0;
                end
                if (!stuck && prev_rd_wait) begin
                    chk("stall_read_held", 64'(avm_read), 64'd1);
                    chk("stall_addr_held", 64'(avm_address), 64'(prev_addr));
                end
                prev_rd_wait = avm_read && avm_waitrequest;
                prev_addr    = avm_address;
                busy_prev    = busy;
            end
        end
    end

    int n;

    initial begin
        repeat (3) tick();
        chk("rst_flags", 64'({busy, done, id_ok, ts_ok, timeout, avm_read, avm_address}), 64'd0);
        chk("rst_values", 64'({id_value, ts_value}), 64'd0);
        chk("rst_count", 64'(mismatch_count), 64'd0);

        // auto-start check with a good zero-wait slave: 1+2+1+2+1 busy cycles
        push_exp(1'b1, 1'b1, 1'b0, 7, 32'd0, GOOD_TS);
        reset = 1'b0;
        repeat (7) tick();
        chk("done_before_check", 64'(done), 64'd0);
        tick();
        chk("done_after_check", 64'(done), 64'd1);
        wait_all();

        // bad timestamp, picked up by the automatic re-check 10 cycles after DONE entry
        ts_word = 32'h12345678;
        push_exp(1'b1, 1'b0, 1'b0, 7, 32'd0, 32'h12345678);
        measure_gap(n);
        chk("recheck_gap", 64'(n), 64'd10);
        wait_all();

        // start in DONE restarts at once; starts while busy are dropped
        push_exp(1'b1, 1'b0, 1'b0, 7, 32'd0, 32'h12345678);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_restart", 64'(busy), 64'd1);
        tick();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        wait_all();

        // three stall cycles per read with latency 2
        ts_word = GOOD_TS;
        stall_n = 3;
        push_exp(1'b1, 1'b1, 1'b0, 13, 32'd0, GOOD_TS);
        measure_gap(n);
        chk("busy_start_ignored", 64'(n), 64'd10);
        wait_all();

        // waitrequest stuck: abandoned after 8 stall cycles
        stuck = 1'b1;
        push_exp(1'b0, 1'b0, 1'b1, 9, 32'd0, GOOD_TS);
        measure_gap(n);
        n = 0;
        while (avm_read && n < 20) begin
            n++;
            tick();
        end
        chk("stuck_read_cycles", 64'(n), 64'd8);
        wait_all();

        // good slave clears timeout
        stuck = 1'b0;
        stall_n = 0;
        push_exp(1'b1, 1'b1, 1'b0, 7, 32'd0, GOOD_TS);
        wait_all();

        // 300 failing checks saturate the mismatch counter
        id_word = 32'd5;
        for (int i = 0; i < 300; i++) push_exp(1'b0, 1'b1, 1'b0, 7, 32'd5, GOOD_TS);
        wait_all();
        chk("mismatch_saturated", 64'(mismatch_count), 64'hFF);

        // reset during RD_TS kills the check; AUTO_START reruns it
        id_word = 32'd0;
        n = 0;
        while (!(avm_read && avm_address) && n < 60) begin
            tick();
            n++;
        end
        chk("reached_rd_ts", 64'(avm_read && avm_address), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_read", 64'(avm_read), 64'd0);
        chk("rst_mid_flags", 64'({busy, done, id_ok, ts_ok, timeout, avm_address}), 64'd0);
        chk("rst_mid_values", 64'({id_value, ts_value}), 64'd0);
        chk("rst_mid_count", 64'(mismatch_count), 64'd0);
        tick();
        exp_mm = 8'd0;
        push_exp(1'b1, 1'b1, 1'b0, 7, 32'd0, GOOD_TS);
        reset = 1'b0;
        wait_all();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
